// File: rtl/seven_segment_scan_driver.sv
// N-digit multiplexed seven-segment driver: hex font, PWM brightness, blanking and
// frame-synchronous display updates. Define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seven_segment_scan_driver #(
  parameter int DIGITS          = 2,
  parameter int PRESCALER_BITS  = 16,
  parameter int BRIGHTNESS_BITS = 4,
  parameter bit COMMON_ANODE    = 1'b1
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic [4*DIGITS-1:0]        code,
  input  logic [DIGITS-1:0]          points,
  input  logic                       load,
  input  logic [BRIGHTNESS_BITS-1:0] brightness,
  input  logic                       blank,
  output logic [7:0]                 segments,
  output logic [DIGITS-1:0]          sel,
  output logic                       frame_done
);

  localparam int                   IDX_BITS = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_BITS-1:0]  LAST_IDX = IDX_BITS'(DIGITS - 1);
  localparam logic [7:0]           SEG_OFF  = {8{COMMON_ANODE}};
  localparam logic [DIGITS-1:0]    SEL_OFF  = {DIGITS{COMMON_ANODE}};

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_font(input logic [3:0] nibble);
    logic [6:0] f;
    case (nibble)
      4'h0: f = 7'h3F;  4'h1: f = 7'h06;  4'h2: f = 7'h5B;  4'h3: f = 7'h4F;
      4'h4: f = 7'h66;  4'h5: f = 7'h6D;  4'h6: f = 7'h7D;  4'h7: f = 7'h07;
      4'h8: f = 7'h7F;  4'h9: f = 7'h6F;  4'hA: f = 7'h77;  4'hB: f = 7'h7C;
      4'hC: f = 7'h39;  4'hD: f = 7'h5E;  4'hE: f = 7'h79;  default: f = 7'h71;
    endcase
    return f;
  endfunction

  logic [PRESCALER_BITS-1:0] prescaler;
  logic [IDX_BITS-1:0]       index;
  logic [4*DIGITS-1:0]       shadow_code, active_code;
  logic [DIGITS-1:0]         shadow_points, active_points;
  logic                      pending;

  logic slot_end, boundary;
  assign slot_end   = &prescaler;
  assign boundary   = slot_end && (index == LAST_IDX);
  assign frame_done = boundary;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      prescaler <= '0;
      index     <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
      if (slot_end) index <= (index == LAST_IDX) ? '0 : index + 1'b1;
    end
  end

  // A load on the boundary cycle bypasses the shadow so it is not deferred a whole frame.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      shadow_code   <= '0;
      shadow_points <= '0;
      active_code   <= '0;
      active_points <= '0;
      pending       <= 1'b0;
    end else begin
      if (load) begin
        shadow_code   <= code;
        shadow_points <= points;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          active_code   <= code;
          active_points <= points;
        end else if (pending) begin
          active_code   <= shadow_code;
          active_points <= shadow_points;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  logic shown;
`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_BITS-1:0] msd;
  always_comb begin
    msd = '0;
    for (int i = 1; i < DIGITS; i++)
      if (active_code[4*i +: 4] != 4'h0 || active_points[i]) msd = IDX_BITS'(i);
    shown = (index <= msd);
  end
`else
  assign shown = 1'b1;
`endif

  logic [3:0]        nibble;
  logic              pwm_on, lit;
  logic [7:0]        seg_hi;
  logic [DIGITS-1:0] sel_hi;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    nibble = active_code[4*index +: 4];
    pwm_on = prescaler[PRESCALER_BITS-1 -: BRIGHTNESS_BITS] < brightness;
    lit    = pwm_on && shown && !blank;
    seg_hi = {active_points[index], hex_font(nibble)};
    sel_hi = DIGITS'(1) << index;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      segments <= SEG_OFF;
      sel      <= SEL_OFF;
    end else if (lit) begin
      segments <= seg_hi ^ SEG_OFF;
      sel      <= sel_hi ^ SEL_OFF;
    end else begin
      segments <= SEG_OFF;
      sel      <= SEL_OFF;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Self-checking bench for seven_segment_scan_driver (4 digits, 16-cycle slots, 2-bit PWM, common anode).
// A cycle model pushes expected outputs on each posedge; scenario tasks pop and compare on the negedge.
module tb_seven_segment_scan_driver;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [15:0] code = '0;
  logic [3:0]  points = '0;
  logic        load = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic        blank = 1'b0;
  logic [7:0]  segments;
  logic [3:0]  sel;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seven_segment_scan_driver #(
    .DIGITS(4), .PRESCALER_BITS(4), .BRIGHTNESS_BITS(2), .COMMON_ANODE(1'b1)
  ) dut (
    .clk(clk), .nreset(nreset), .code(code), .points(points), .load(load),
    .brightness(brightness), .blank(blank), .segments(segments), .sel(sel),
    .frame_done(frame_done)
  );

  function automatic logic [6:0] font7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Expected {segments, sel} driven by the display for one model state (common anode).
  function automatic logic [11:0] exp_disp(input logic [3:0] pre, input logic [1:0] idx,
                                           input logic [15:0] c, input logic [3:0] p,
                                           input logic [1:0] b, input logic blk);
    logic [3:0] nib;
    logic       on;
    logic [3:0] onehot;
    nib    = c[idx*4 +: 4];
    on     = !blk && (pre[3:2] < b);
`ifdef LEADING_ZERO_BLANK_EN
    begin
      int msd;
      msd = 0;
      for (int i = 0; i < 4; i++) if (c[i*4 +: 4] != 4'h0 || p[i]) msd = i;
      if (int'(idx) > msd) on = 1'b0;
    end
`endif
    onehot = 4'b0001 << idx;
    if (!on) return 12'hFFF;
    return {~{p[idx], font7(nib)}, ~onehot};
  endfunction

  // Cycle model and scoreboard producer.
  logic [3:0]  m_pre, m_pts, m_sh_pts;
  logic [1:0]  m_idx;
  logic [15:0] m_code, m_sh_code;
  logic        m_pend;
  logic [12:0] sb[$];

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_pre <= '0; m_idx <= '0; m_code <= '0; m_pts <= '0;
      m_sh_code <= '0; m_sh_pts <= '0; m_pend <= 1'b0;
      sb.delete();
    end else begin
      sb.push_back({exp_disp(m_pre, m_idx, m_code, m_pts, brightness, blank),
                    (m_pre == 4'd14 && m_idx == 2'd3)});
      m_pre <= m_pre + 4'd1;
      if (m_pre == 4'd15) m_idx <= m_idx + 2'd1;
      if (m_pre == 4'd15 && m_idx == 2'd3) begin
        m_pend <= 1'b0;
        if (load) begin
          m_code <= code; m_pts <= points;
        end else if (m_pend) begin
          m_code <= m_sh_code; m_pts <= m_sh_pts;
        end
      end else if (load) begin
        m_sh_code <= code; m_sh_pts <= points; m_pend <= 1'b1;
      end
    end
  end

  task automatic test_reset;
    logic [12:0] e;
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (segments !== 8'hFF || sel !== 4'hF || frame_done !== 1'b0) begin
      bad++; $display("FAIL reset_hold: got seg=%h sel=%b fd=%b want seg=ff sel=1111 fd=0", segments, sel, frame_done);
    end
    nreset = 1'b1;
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL reset_sb cyc%0d: no expected entry", c); end
      else begin
        e = sb.pop_front();
        if ({segments, sel, frame_done} !== e) begin
          bad++; $display("FAIL reset_sb cyc%0d: got %h/%b/%b want %h/%b/%b", c, segments, sel, frame_done, e[12:5], e[4:1], e[0]);
        end
      end
    end
    @(posedge clk); #3; nreset = 1'b0; #1;
    total++;
    if (segments !== 8'hFF || sel !== 4'hF) begin
      bad++; $display("FAIL reset_mid: got seg=%h sel=%b want seg=ff sel=1111", segments, sel);
    end
    @(negedge clk); @(negedge clk);
    nreset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL reset_restart_sb cyc%0d: no expected entry", c); end
      else begin
        e = sb.pop_front();
        if ({segments, sel, frame_done} !== e) begin
          bad++; $display("FAIL reset_restart_sb cyc%0d: got %h/%b/%b want %h/%b/%b", c, segments, sel, frame_done, e[12:5], e[4:1], e[0]);
        end
      end
      if (c == 0) begin
        total++;
        if (sel !== 4'b1110 || segments !== 8'hC0) begin
          bad++; $display("FAIL reset_restart_idx: got seg=%h sel=%b want seg=c0 sel=1110", segments, sel);
        end
      end
    end
  endtask

  // Frame-aligned check of 1234 under brightness 3, plus the frame_done period.
  task automatic test_hex;
    logic [12:0] e;
    logic [7:0]  dig [4];
    logic [3:0]  es;
    int ok [4];
    int win, last_fd, fds, k, p;
    dig = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    ok = '{default: 0};
    win = -2; last_fd = -1; fds = 0;
    code = 16'h1234; points = 4'h0; load = 1'b1;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      load = 1'b0;
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL hex_sb cyc%0d: no expected entry", c); end
      else begin
        e = sb.pop_front();
        if ({segments, sel, frame_done} !== e) begin
          bad++; $display("FAIL hex_sb cyc%0d: got %h/%b/%b want %h/%b/%b", c, segments, sel, frame_done, e[12:5], e[4:1], e[0]);
        end
      end
      if (frame_done) begin
        if (last_fd >= 0) begin
          total++;
          if (c - last_fd != 64) begin bad++; $display("FAIL hex_period: got %0d want 64", c - last_fd); end
        end
        last_fd = c; fds++;
      end
      if (win >= 0 && win < 64) begin
        k = win / 16; p = win % 16;
        es = ~(4'b0001 << k);
        if (p < 12 ? (sel === es && segments === dig[k]) : (sel === 4'hF && segments === 8'hFF)) ok[k]++;
      end
      if (win > -2) win++;
      else if (frame_done) win = -1;
    end
    for (int d = 0; d < 4; d++) begin
      total++;
      if (ok[d] != 16) begin bad++; $display("FAIL hex_digit%0d: got %0d good cycles want 16", d, ok[d]); end
    end
    total++;
    if (fds < 2) begin bad++; $display("FAIL hex_frames: got %0d frame_done pulses want >=2", fds); end
  endtask

  // Duty per digit for brightness 1 (4 of 16) and 0 (dark).
  task automatic test_brightness;
    logic [12:0] e;
    logic [7:0]  dig [4];
    logic [3:0]  es;
    int ok [4];
    int win, k, p, bv;
    dig = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    for (int bi = 0; bi < 2; bi++) begin
      bv = (bi == 0) ? 1 : 0;
      brightness = 2'(bv);
      ok = '{default: 0};
      win = -2;
      for (int c = 0; c < 140; c++) begin
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL bright%0d_sb cyc%0d: no expected entry", bv, c); end
        else begin
          e = sb.pop_front();
          if ({segments, sel, frame_done} !== e) begin
            bad++; $display("FAIL bright%0d_sb cyc%0d: got %h/%b/%b want %h/%b/%b", bv, c, segments, sel, frame_done, e[12:5], e[4:1], e[0]);
          end
        end
        if (win >= 0 && win < 64) begin
          k = win / 16; p = win % 16;
          es = ~(4'b0001 << k);
          if (p < 4 * bv ? (sel === es && segments === dig[k]) : (sel === 4'hF && segments === 8'hFF)) ok[k]++;
        end
        if (win > -2) win++;
        else if (frame_done) win = -1;
      end
      for (int d = 0; d < 4; d++) begin
        total++;
        if (ok[d] != 16) begin bad++; $display("FAIL bright%0d_digit%0d: got %0d good cycles want 16", bv, d, ok[d]); end
      end
    end
    brightness = 2'd3;
  endtask

  // Two loads in one frame: only the last shows, and only from the next frame.
  task automatic test_last_wins;
    logic [12:0] e;
    int win, a_seen, early5, late5;
    win = -2; a_seen = 0; early5 = 0; late5 = 0;
    for (int c = 0; c < 210; c++) begin
      @(negedge clk);
      load = 1'b0;
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL last_sb cyc%0d: no expected entry", c); end
      else begin
        e = sb.pop_front();
        if ({segments, sel, frame_done} !== e) begin
          bad++; $display("FAIL last_sb cyc%0d: got %h/%b/%b want %h/%b/%b", c, segments, sel, frame_done, e[12:5], e[4:1], e[0]);
        end
      end
      if (win == 2)  begin code = 16'hAAAA; points = 4'h0; load = 1'b1; end
      if (win == 10) begin code = 16'h5555; points = 4'h0; load = 1'b1; end
      if (segments === 8'h88) a_seen++;
      if (win >= 0 && win < 64 && segments === 8'h92) early5++;
      if (win >= 64 && win < 128 && segments === 8'h92) late5++;
      if (win > -2) win++;
      else if (frame_done) win = -1;
    end
    total++;
    if (a_seen != 0) begin bad++; $display("FAIL last_a_shown: got %0d cycles of A want 0", a_seen); end
    total++;
    if (early5 != 0) begin bad++; $display("FAIL last_midframe: got %0d early cycles of 5 want 0", early5); end
    total++;
    if (late5 != 48) begin bad++; $display("FAIL last_next_frame: got %0d cycles of 5 want 48", late5); end
  endtask

  // Load on the boundary cycle takes effect in the very next frame.
  task automatic test_load_boundary;
    logic [12:0] e;
    int win, d0, d1;
    win = -2; d0 = 0; d1 = 0;
    for (int c = 0; c < 110; c++) begin
      @(negedge clk);
      load = 1'b0;
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL bnd_sb cyc%0d: no expected entry", c); end
      else begin
        e = sb.pop_front();
        if ({segments, sel, frame_done} !== e) begin
          bad++; $display("FAIL bnd_sb cyc%0d: got %h/%b/%b want %h/%b/%b", c, segments, sel, frame_done, e[12:5], e[4:1], e[0]);
        end
      end
      if (win == -2 && frame_done) begin code = 16'h8888; points = 4'b0001; load = 1'b1; end
      if (win >= 0 && win < 32) begin
        if (sel === 4'b1110 && segments === 8'h00) d0++;
        if (sel === 4'b1101 && segments === 8'h80) d1++;
      end
      if (win > -2) win++;
      else if (frame_done) win = -1;
    end
    total++;
    if (d0 != 12) begin bad++; $display("FAIL bnd_digit0: got %0d lit cycles want 12", d0); end
    total++;
    if (d1 != 12) begin bad++; $display("FAIL bnd_digit1: got %0d lit cycles want 12", d1); end
  endtask

  // Blank for 10 cycles: outputs dark, frame timing untouched.
  task automatic test_blank;
    logic [12:0] e;
    int win, off, last_fd, periods;
    win = -2; off = 0; last_fd = -1; periods = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL blank_sb cyc%0d: no expected entry", c); end
      else begin
        e = sb.pop_front();
        if ({segments, sel, frame_done} !== e) begin
          bad++; $display("FAIL blank_sb cyc%0d: got %h/%b/%b want %h/%b/%b", c, segments, sel, frame_done, e[12:5], e[4:1], e[0]);
        end
      end
      if (win == 20) blank = 1'b1;
      if (win == 30) blank = 1'b0;
      if (win >= 21 && win <= 30 && segments === 8'hFF && sel === 4'hF) off++;
      if (frame_done) begin
        if (last_fd >= 0) begin
          total++; periods++;
          if (c - last_fd != 64) begin bad++; $display("FAIL blank_period: got %0d want 64", c - last_fd); end
        end
        last_fd = c;
      end
      if (win > -2) win++;
      else if (frame_done) win = -1;
    end
    blank = 1'b0;
    total++;
    if (off != 10) begin bad++; $display("FAIL blank_dark: got %0d dark cycles want 10", off); end
    total++;
    if (periods < 1) begin bad++; $display("FAIL blank_frames: got %0d periods want >=1", periods); end
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_lzb;
    logic [12:0] e;
    int win, hi_sel, d_lit;
    for (int ci = 0; ci < 2; ci++) begin
      code = (ci == 0) ? 16'h0070 : 16'h0000; points = 4'h0; load = 1'b1;
      win = -2; hi_sel = 0; d_lit = 0;
      for (int c = 0; c < 140; c++) begin
        @(negedge clk);
        load = 1'b0;
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL lzb_sb cyc%0d: no expected entry", c); end
        else begin
          e = sb.pop_front();
          if ({segments, sel, frame_done} !== e) begin
            bad++; $display("FAIL lzb_sb cyc%0d: got %h/%b/%b want %h/%b/%b", c, segments, sel, frame_done, e[12:5], e[4:1], e[0]);
          end
        end
        if (win >= 0 && win < 64) begin
          if (ci == 0 && sel[3:2] !== 2'b11) hi_sel++;
          if (ci == 1 && sel[3:1] !== 3'b111) hi_sel++;
          if (ci == 0 && sel === 4'b1101 && segments === 8'hF8) d_lit++;
          if (ci == 1 && sel === 4'b1110 && segments === 8'hC0) d_lit++;
        end
        if (win > -2) win++;
        else if (frame_done) win = -1;
      end
      total++;
      if (hi_sel != 0) begin bad++; $display("FAIL lzb_case%0d_hi: got %0d selected cycles want 0", ci, hi_sel); end
      total++;
      if (d_lit != 12) begin bad++; $display("FAIL lzb_case%0d_lit: got %0d lit cycles want 12", ci, d_lit); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hex();
    test_brightness();
    test_last_wins();
    test_load_boundary();
    test_blank();
`ifdef LEADING_ZERO_BLANK_EN
    test_lzb();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
